// File: rtl/slink_rx_lane_deskew.sv
// Receive-side lane deskew: buffers early lanes so every lane presents its sync byte in the same cycle.
// Optional post-lock alignment check and relock enabled by defining SLINK_DESKEW_RELOCK_EN.
module slink_rx_lane_deskew #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_LANES  = 4,
  parameter int DEPTH      = 8,
  parameter logic [DATA_WIDTH-1:0] SYNC_SYMBOL = 8'hBC
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] rx_data,
  input  logic                            rx_data_ctrl,
  output logic [NUM_LANES*DATA_WIDTH-1:0] des_data,
  output logic                            des_data_ctrl,
  output logic                            des_valid,
  output logic                            locked,
  output logic                            skew_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int SW = PW + 1;
  localparam logic [SW-1:0] SKEW_ERR_AT = SW'(DEPTH - 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SEARCH    = 3'd1;
  localparam logic [2:0] ST_WAIT_ALL  = 3'd2;
  localparam logic [2:0] ST_LOCK_LOAD = 3'd3;
  localparam logic [2:0] ST_LOCKED    = 3'd4;

  logic [2:0]                      state;
  logic [PW-1:0]                   wptr;
  logic [PW-1:0]                   rptr [NUM_LANES];
  logic [PW-1:0]                   cap  [NUM_LANES];
  logic [NUM_LANES-1:0]            seen;
  logic [NUM_LANES-1:0]            hit;
  logic [NUM_LANES-1:0]            seen_nxt;
  logic [SW-1:0]                   skew_cnt;
  logic [SW-1:0]                   skew_inc;
  logic [DATA_WIDTH-1:0]           lane_buf [NUM_LANES][DEPTH];
  logic                            ctrl_buf [DEPTH];
  logic [NUM_LANES*DATA_WIDTH-1:0] rd_word;
  logic [NUM_LANES*DATA_WIDTH-1:0] rd_p0;
  logic                            ctrl_p0;
  logic                            vld_p0;
`ifdef SLINK_DESKEW_RELOCK_EN
  logic [NUM_LANES-1:0]            rd_sync;
`endif

  always_comb begin
    hit     = '0;
    rd_word = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      hit[i] = (rx_data[i*DATA_WIDTH +: DATA_WIDTH] == SYNC_SYMBOL);
      rd_word[i*DATA_WIDTH +: DATA_WIDTH] = lane_buf[i][rptr[i]];
    end
    seen_nxt = seen | hit;
    skew_inc = skew_cnt + 1'b1;
  end

`ifdef SLINK_DESKEW_RELOCK_EN
  always_comb begin
    rd_sync = '0;
    for (int i = 0; i < NUM_LANES; i++)
      rd_sync[i] = (rd_p0[i*DATA_WIDTH +: DATA_WIDTH] == SYNC_SYMBOL);
  end
`endif

  // Lane buffers: shared write pointer, contents never reset
  always_ff @(posedge clk) begin
    if (enable) begin
      for (int i = 0; i < NUM_LANES; i++)
        lane_buf[i][wptr] <= rx_data[i*DATA_WIDTH +: DATA_WIDTH];
      ctrl_buf[wptr] <= rx_data_ctrl;
    end
  end

  // Stage p0: aligned read out of the buffers
  always_ff @(posedge clk) begin
    if (enable && state == ST_LOCKED) begin
      rd_p0   <= rd_word;
      ctrl_p0 <= ctrl_buf[rptr[0]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      wptr          <= '0;
      seen          <= '0;
      skew_cnt      <= '0;
      vld_p0        <= 1'b0;
      des_data      <= '0;
      des_data_ctrl <= 1'b0;
      des_valid     <= 1'b0;
      locked        <= 1'b0;
      skew_err      <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) rptr[i] <= '0;
    end else if (!enable) begin
      state         <= ST_IDLE;
      seen          <= '0;
      vld_p0        <= 1'b0;
      des_data      <= '0;
      des_data_ctrl <= 1'b0;
      des_valid     <= 1'b0;
      locked        <= 1'b0;
      skew_err      <= 1'b0;
    end else begin
      wptr     <= wptr + 1'b1;
      skew_err <= 1'b0;
      vld_p0   <= 1'b0;
      // Output stage: registered from p0, zeroed whenever not aligned
      des_data      <= vld_p0 ? rd_p0 : '0;
      des_data_ctrl <= vld_p0 & ctrl_p0;
      des_valid     <= vld_p0;
      locked        <= vld_p0;
      case (state)
        ST_IDLE: state <= ST_SEARCH;
        ST_SEARCH: begin
          if (|hit) begin
            for (int i = 0; i < NUM_LANES; i++)
              if (hit[i]) cap[i] <= wptr;
            seen     <= hit;
            skew_cnt <= '0;
            state    <= (&hit) ? ST_LOCK_LOAD : ST_WAIT_ALL;
          end
        end
        ST_WAIT_ALL: begin
          skew_cnt <= skew_inc;
          // Timeout cycle ignores any hits that arrive with it
          if (skew_inc >= SKEW_ERR_AT) begin
            skew_err <= 1'b1;
            seen     <= '0;
            state    <= ST_SEARCH;
          end else begin
            for (int i = 0; i < NUM_LANES; i++)
              if (hit[i] && !seen[i]) cap[i] <= wptr;
            seen <= seen_nxt;
            if (&seen_nxt) state <= ST_LOCK_LOAD;
          end
        end
        ST_LOCK_LOAD: begin
          for (int i = 0; i < NUM_LANES; i++) rptr[i] <= cap[i];
          state <= ST_LOCKED;
        end
        ST_LOCKED: begin
          vld_p0 <= 1'b1;
          for (int i = 0; i < NUM_LANES; i++) rptr[i] <= rptr[i] + 1'b1;
`ifdef SLINK_DESKEW_RELOCK_EN
          if (vld_p0 && (|rd_sync) && !(&rd_sync)) begin
            skew_err <= 1'b1;
            seen     <= '0;
            vld_p0   <= 1'b0;
            state    <= ST_SEARCH;
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slink_rx_lane_deskew.sv
// Directed bench for slink_rx_lane_deskew: zero skew, max skew, missing lane, ctrl, enable drop, reset, slip.
module tb_slink_rx_lane_deskew;
  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] rx_data;
  logic        rx_data_ctrl;
  logic [31:0] des_data;
  logic        des_data_ctrl;
  logic        des_valid;
  logic        locked;
  logic        skew_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int d[4];
  int off[4];
  int ex1[4];
  int t0, tc, ex_all;

  always #5 clk = ~clk;

  slink_rx_lane_deskew dut (
    .clk(clk), .reset(reset), .enable(enable),
    .rx_data(rx_data), .rx_data_ctrl(rx_data_ctrl),
    .des_data(des_data), .des_data_ctrl(des_data_ctrl),
    .des_valid(des_valid), .locked(locked), .skew_err(skew_err)
  );

  initial begin
    #100000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  // Byte driven on lane i in cycle c: filler, one sync at t0+d[i], then an incrementing count
  function automatic logic [7:0] lane_byte(input int i, input int c);
    int k;
    if (c == ex_all || c == ex1[i]) return 8'hBC;
    if (i == 0 && c == tc) return 8'h5A;
    if (d[i] < 0) return 8'(17 * (i + 1));
    k = c - t0 - d[i];
    if (k < 0) return 8'(17 * (i + 1));
    if (k == 0) return 8'hBC;
    return 8'(k + i * 32);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_inputs(input int c);
    for (int i = 0; i < 4; i++) rx_data[i*8 +: 8] = lane_byte(i, c);
    rx_data_ctrl = (c == tc);
  endtask

  task automatic run(input int ncyc, input int lock_from, input int lock_to,
                     input int err_at, input int lock2_from);
    logic [31:0] exp_d;
    logic        exp_c;
    logic        lk;
    enable = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      cyc = c;
      drive_inputs(c);
      tick();
      lk = (c >= lock_from && c < lock_to) || (lock2_from > 0 && c >= lock2_from);
      exp_d = '0;
      exp_c = 1'b0;
      if (lk) begin
        for (int i = 0; i < 4; i++) exp_d[i*8 +: 8] = lane_byte(i, c - off[i]);
        exp_c = (c - off[0] == tc);
      end
      chk("locked", {31'b0, locked}, {31'b0, lk});
      chk("des_valid", {31'b0, des_valid}, {31'b0, lk});
      chk("skew_err", {31'b0, skew_err}, {31'b0, (c == err_at)});
      chk("des_data", des_data, exp_d);
      chk("des_ctrl", {31'b0, des_data_ctrl}, {31'b0, exp_c});
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_data"}, des_data, 32'h0);
    chk({tag, "_ctrl"}, {31'b0, des_data_ctrl}, 32'h0);
    chk({tag, "_valid"}, {31'b0, des_valid}, 32'h0);
    chk({tag, "_locked"}, {31'b0, locked}, 32'h0);
    chk({tag, "_skew_err"}, {31'b0, skew_err}, 32'h0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; rx_data = '0; rx_data_ctrl = 1'b0;
    d = '{0, 0, 0, 0}; off = '{3, 3, 3, 3}; ex1 = '{-1, -1, -1, -1};
    t0 = 10; tc = -100; ex_all = -1;
    tick(); tick();
    chk_idle_outputs("reset");
    reset = 1'b0;
    tick();

    // Zero skew, ctrl flag with lane-0 byte 5A at cycle 17
    tc = 17;
    run(40, 13, 1000, -1, -1);
    enable = 1'b0; cyc = 41; drive_inputs(41);
    tick();
    chk_idle_outputs("en_drop");
    tc = -100;

    // Skew 6 (lanes at 10/11/13/16)
    d = '{0, 1, 3, 6}; off = '{9, 8, 6, 3};
    run(30, 19, 1000, -1, -1);
    enable = 1'b0; tick();

    // Lane 3 never syncs: timeout at 17, then all lanes sync at 25
    d = '{0, 0, 0, -1}; off = '{3, 3, 3, 3}; ex_all = 25;
    run(35, 28, 1000, 17, -1);
    enable = 1'b0; tick();

    // Lane 2 slips by one cycle after lock, aligned sync again at 30
    d = '{0, 0, 0, 0}; ex1 = '{20, 20, 21, 20}; ex_all = 30;
`ifdef SLINK_DESKEW_RELOCK_EN
    run(36, 13, 24, 23, 33);
`else
    run(36, 13, 1000, -1, -1);
`endif
    enable = 1'b0; tick();
    ex1 = '{-1, -1, -1, -1}; ex_all = -1;

    // Reset asserted while waiting for lanes 1-3
    d = '{0, 5, 5, 5};
    run(12, 1000, 1000, -1, -1);
    reset = 1'b1; cyc = 13;
    tick();
    chk_idle_outputs("reset_wait");
    reset = 1'b0; rx_data = '0;
    for (int c = 14; c < 24; c++) begin
      cyc = c;
      tick();
      chk("post_reset_skew_err", {31'b0, skew_err}, 32'h0);
      chk("post_reset_locked", {31'b0, locked}, 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
